axi_master_read: RTL and testbench



---
 rtl/axi_master_read_if.sv | 37 +++
 rtl/axi_master_read.sv | 124 ++++++++++++
 tb/tb_axi_master_read.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_read_if.sv
// AXI4 read-address and read-data channels for axi_master_read.
// master drives AR and RREADY; slave drives ARREADY and the R beat.
interface axi_master_read_if;
    logic [3:0]  M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARLOCK;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic [3:0]  M_AXI_ARQOS;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [3:0]  M_AXI_RID;
    logic [63:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
        output M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT,
        output M_AXI_ARQOS, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RLAST, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
        input  M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT,
        input  M_AXI_ARQOS, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RLAST, M_AXI_RVALID
    );
endinterface

// File: rtl/axi_master_read.sv
// Single-outstanding AXI4 INCR read master streaming beats into a FIFO.
// Define AXI_RD_CHECK_EN to flag bad RRESP/RLAST on the sticky RD_ERR.
module axi_master_read (
    input  logic              ACLK,
    input  logic              ARESETN,
    axi_master_read_if.master m_axi,
    input  logic              RD_START,
    input  logic [31:0]       RD_ADRS,
    input  logic [9:0]        RD_LEN,
    output logic              RD_READY,
    output logic              RD_FIFO_WE,
    output logic [63:0]       RD_FIFO_DATA,
    output logic              RD_DONE,
    output logic              RD_ERR
);

    typedef enum logic [2:0] {
        S_RD_IDLE  = 3'd0,
        S_RA_WAIT  = 3'd1,
        S_RA_START = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_PROC  = 3'd4,
        S_RD_DONE  = 3'd5
    } state_e;

    state_e      state_q;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [7:0]  cnt_q;
    logic        len_ok;
    logic [7:0]  len_m1;
    logic        beat;

    // 256 wraps to 0 in the low byte, so the minus-one still yields 8'hFF
    assign len_ok = (RD_LEN != 10'd0) && (RD_LEN <= 10'd256);
    assign len_m1 = RD_LEN[7:0] - 8'd1;
    assign beat   = m_axi.M_AXI_RVALID && (state_q == S_RD_PROC);

    assign m_axi.M_AXI_ARID    = 4'b1111;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARLEN   = arlen_q;
    assign m_axi.M_AXI_ARSIZE  = 3'b011;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARLOCK  = 1'b0;
    assign m_axi.M_AXI_ARCACHE = 4'b0010;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARQOS   = 4'b0000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = (state_q == S_RD_PROC);

    assign RD_READY     = (state_q == S_RD_IDLE);
    assign RD_DONE      = (state_q == S_RD_DONE);
    assign RD_FIFO_WE   = beat;
    assign RD_FIFO_DATA = m_axi.M_AXI_RDATA;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_RD_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            cnt_q     <= 8'd0;
        end else begin
            unique case (state_q)
                S_RD_IDLE: begin
                    if (RD_START && len_ok) begin
                        araddr_q <= RD_ADRS;
                        arlen_q  <= len_m1;
                        cnt_q    <= len_m1;
                        state_q  <= S_RA_WAIT;
                    end
                end
                S_RA_WAIT: state_q <= S_RA_START;
                S_RA_START: begin
                    arvalid_q <= 1'b1;
                    state_q   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_RD_PROC;
                    end
                end
                // the beat counter, not RLAST, ends the burst
                S_RD_PROC: begin
                    if (beat) begin
                        if (cnt_q == 8'd0) state_q <= S_RD_DONE;
                        else               cnt_q   <= cnt_q - 8'd1;
                    end
                end
                S_RD_DONE: state_q <= S_RD_IDLE;
                default: begin
                    state_q   <= S_RD_IDLE;
                    arvalid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_RD_CHECK_EN
    logic err_q;
    logic unused_rid;

    assign unused_rid = ^m_axi.M_AXI_RID;
    assign RD_ERR     = err_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q <= 1'b0;
        end else if (beat && ((m_axi.M_AXI_RRESP != 2'b00) ||
                     (m_axi.M_AXI_RLAST != (cnt_q == 8'd0)))) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_rsp;

    assign unused_rsp = ^{m_axi.M_AXI_RID, m_axi.M_AXI_RRESP,
                          m_axi.M_AXI_RLAST};
    assign RD_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_read.sv
// Scoreboard bench for axi_master_read: directed bursts, AXI slave model,
// FIFO-write monitor popping expected beats from a queue.
`timescale 1ns/1ps
module tb_axi_master_read;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        RD_START;
    logic [31:0] RD_ADRS;
    logic [9:0]  RD_LEN;
    logic        RD_READY;
    logic        RD_FIFO_WE;
    logic [63:0] RD_FIFO_DATA;
    logic        RD_DONE;
    logic        RD_ERR;

    always #5 ACLK = ~ACLK;

    axi_master_read_if bus ();

    axi_master_read u_dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .m_axi        (bus),
        .RD_START     (RD_START),
        .RD_ADRS      (RD_ADRS),
        .RD_LEN       (RD_LEN),
        .RD_READY     (RD_READY),
        .RD_FIFO_WE   (RD_FIFO_WE),
        .RD_FIFO_DATA (RD_FIFO_DATA),
        .RD_DONE      (RD_DONE),
        .RD_ERR       (RD_ERR)
    );

`ifdef AXI_RD_CHECK_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    int          vecs;
    int          errs;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a,
                                              input int i);
        logic [31:0] hi;
        hi = a + 32'(i * 8);
        return {hi, 32'hC0DE_0000 | 32'(i)};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arvalid"}, 64'(bus.M_AXI_ARVALID), 64'd0);
        chk({tag, "_rready"},  64'(bus.M_AXI_RREADY), 64'd0);
        chk({tag, "_fifo_we"}, 64'(RD_FIFO_WE), 64'd0);
        chk({tag, "_done"},    64'(RD_DONE), 64'd0);
        chk({tag, "_err"},     64'(RD_ERR), 64'd0);
        chk({tag, "_araddr"},  64'(bus.M_AXI_ARADDR), 64'd0);
        chk({tag, "_arlen"},   64'(bus.M_AXI_ARLEN), 64'd0);
        chk({tag, "_ready"},   64'(RD_READY), 64'd1);
    endtask

    task automatic run_burst(input logic [31:0] a, input int len,
                             input int ard, input bit gaps,
                             input int rst_beat, input int err_beat,
                             input bit exp_err);
        int lat;
        bit seen;
        int g;
        @(posedge ACLK); #1;
        chk("ready_before", 64'(RD_READY), 64'd1);
        for (int i = 0; i < len; i++) exp_q.push_back(beat_data(a, i));
        RD_ADRS  = a;
        RD_LEN   = 10'(len);
        RD_START = 1'b1;
        @(posedge ACLK); #1;
        RD_START = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (bus.M_AXI_ARVALID === 1'b1) begin
                seen = 1'b1;
                break;
            end
            lat++;
        end
        if (!seen) begin
            chk("arvalid_timeout", 64'd0, 64'd1);
            exp_q.delete();
            return;
        end
        chk("start_latency", 64'(lat), 64'd2);
        chk("araddr", 64'(bus.M_AXI_ARADDR), 64'(a));
        chk("arlen", 64'(bus.M_AXI_ARLEN), 64'(len - 1));
        chk("rready_pre_hs", 64'(bus.M_AXI_RREADY), 64'd0);
        for (int d = 0; d < ard; d++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            chk("arvalid_held", 64'(bus.M_AXI_ARVALID), 64'd1);
            chk("araddr_stable", 64'(bus.M_AXI_ARADDR), 64'(a));
            chk("arlen_stable", 64'(bus.M_AXI_ARLEN), 64'(len - 1));
            chk("rready_wait", 64'(bus.M_AXI_RREADY), 64'd0);
        end
        bus.M_AXI_ARREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.M_AXI_ARREADY = 1'b0;
        @(negedge ACLK);
        chk("arvalid_clear", 64'(bus.M_AXI_ARVALID), 64'd0);
        chk("rready_proc", 64'(bus.M_AXI_RREADY), 64'd1);
        @(posedge ACLK); #1;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge ACLK); #1;
                end
            end
            bus.M_AXI_RVALID = 1'b1;
            bus.M_AXI_RDATA  = beat_data(a, i);
            bus.M_AXI_RLAST  = (i == len - 1);
            bus.M_AXI_RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
            if (i == rst_beat) begin
                #2 ARESETN = 1'b0;
                #1;
                chk_reset_vals("midrst");
                bus.M_AXI_RVALID = 1'b0;
                bus.M_AXI_RLAST  = 1'b0;
                exp_q.delete();
                @(posedge ACLK); #1;
                ARESETN = 1'b1;
                return;
            end
            @(posedge ACLK); #1;
            bus.M_AXI_RVALID = 1'b0;
        end
        bus.M_AXI_RLAST = 1'b0;
        bus.M_AXI_RRESP = 2'b00;
        @(negedge ACLK);
        chk("done_pulse", 64'(RD_DONE), 64'd1);
        chk("ready_in_done", 64'(RD_READY), 64'd0);
        chk("err_at_done", 64'(RD_ERR), 64'(exp_err));
        @(negedge ACLK);
        chk("done_clear", 64'(RD_DONE), 64'd0);
        chk("ready_after", 64'(RD_READY), 64'd1);
        chk("err_after", 64'(RD_ERR), 64'(exp_err));
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic bad_req(input int len);
        @(posedge ACLK); #1;
        RD_ADRS  = 32'h0000_0800;
        RD_LEN   = 10'(len);
        RD_START = 1'b1;
        @(posedge ACLK); #1;
        RD_START = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ACLK);
            chk("bad_arvalid", 64'(bus.M_AXI_ARVALID), 64'd0);
            chk("bad_ready", 64'(RD_READY), 64'd1);
        end
    endtask

    initial begin
        vecs              = 0;
        errs              = 0;
        ARESETN           = 1'b0;
        RD_START          = 1'b0;
        RD_ADRS           = 32'd0;
        RD_LEN            = 10'd0;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RID     = 4'hF;
        bus.M_AXI_RDATA   = 64'd0;
        bus.M_AXI_RRESP   = 2'b00;
        bus.M_AXI_RLAST   = 1'b0;
        bus.M_AXI_RVALID  = 1'b0;
        fork
            forever begin
                @(negedge ACLK);
                if (ARESETN === 1'b1 && RD_FIFO_WE === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL fifo_extra: got write %0h expected none",
                                 RD_FIFO_DATA);
                    end else begin
                        chk("fifo_data", RD_FIFO_DATA, exp_q.pop_front());
                    end
                end
            end
            begin
                #2000000;
                $display("FAIL watchdog: got timeout expected $finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_vals("rst");
        chk("ar_consts",
            {39'd0, bus.M_AXI_ARID, bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST,
             bus.M_AXI_ARLOCK, bus.M_AXI_ARCACHE, bus.M_AXI_ARPROT,
             bus.M_AXI_ARQOS},
            {39'd0, 4'b1111, 3'b011, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk_reset_vals("idle");

        run_burst(32'h0000_0100, 1, 0, 1'b0, -1, -1, 1'b0);
        run_burst(32'h0000_2000, 256, 0, 1'b1, -1, -1, 1'b0);
        run_burst(32'h0000_3000, 128, 10, 1'b0, -1, -1, 1'b0);
        bad_req(0);
        bad_req(300);
        run_burst(32'h0000_4000, 16, 0, 1'b0, 5, -1, 1'b0);
        run_burst(32'h0000_5000, 4, 0, 1'b0, -1, -1, 1'b0);
        run_burst(32'h0000_6000, 8, 0, 1'b0, -1, 2, ERR_EXP);

        repeat (2) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
